// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, fetches one instruction at a time over a req/ack
// handshake, holds it across stalls, redirects on branches and counts retires.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_RData,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  output logic [24:0] ImmExt_In,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Misaligned,
  output logic [31:0] Retired
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic        bad_target;

  assign PCPlus4    = PC + 32'd4;
  assign next_pc    = PCSrc ? PCTarget : PCPlus4;
  assign bad_target = PCSrc && (PCTarget[1:0] != 2'b00);

  // NOTE: reset is gated in directly so the request drops the moment reset
  // asserts, rather than one clock later when the state register is cleared.
  assign IMem_Req  = (state == FETCH) && !reset;
  assign IMem_Addr = PC;
  assign ImmExt_In = Instr[31:7];

  // NOTE: all state lives in one clocked block using non-blocking assignments,
  // so every register sees the values from before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      PC          <= RESET_PC;
      Instr       <= NOP;
      Instr_Valid <= 1'b0;
      Misaligned  <= 1'b0;
      Retired     <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (IMem_Ack) begin
            Instr       <= IMem_RData;
            Instr_Valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!Stall) begin
            Retired     <= Retired + 32'd1;
            Instr_Valid <= 1'b0;
            if (bad_target) begin
              // The PC keeps pointing at the offending branch for debug.
              Misaligned <= 1'b1;
              state      <= HALT;
            end else begin
              PC    <= next_pc;
              state <= FETCH;
            end
          end
        end
        HALT: begin
          Instr_Valid <= 1'b0;
        end
        default: begin
          Instr_Valid <= 1'b0;
          state       <= HALT;
        end
      endcase
    end
  end

endmodule
